// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_pkg
//  Brief    : Shared widths, flag indices and stage-1 payload for the
//             single-precision normalize/round stage.
//  Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Bit positions inside the {overflow, underflow, inexact} flag vector
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  // Payload carried from the normalize register into the round logic.
  // zero=1 means "emit a signed zero with the carried flags" (exact zero
  // arrives here with sign already cleared, flush-to-zero keeps the sign).
  typedef struct packed {
    logic                sign;
    logic signed [9:0]   exp10;
    logic [FRAC_W:0]     mant24;
    logic [2:0]          grs;
    logic                special;
    logic                zero;
    logic [2:0]          flags;
  } s1_payload_t;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/lzc24.sv
`default_nettype none
// ============================================================================
//  Module   : lzc24
//  Brief    : Combinational 24-bit leading-zero counter; all-zero input
//             reports 24.
//  Revision : 1.0 - initial release
// ============================================================================
module lzc24 (
  input  logic [23:0] data_i,
  output logic [4:0]  count_o
);

  // Scan upward so the highest set bit writes last and wins
  always_comb begin
    count_o = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (data_i[i]) count_o = 5'(23 - i);
    end
  end

endmodule : lzc24
`default_nettype wire

// File: rtl/fp_norm_round.sv
`default_nettype none
// ============================================================================
//  Module   : fp_norm_round
//  Brief    : Two-stage valid/ready normalize + round-to-nearest-even stage
//             producing a packed IEEE-754 single and {ovf, unf, inx} flags.
//  Revision : 1.0 - initial release
// ============================================================================
module fp_norm_round
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  input  logic [2:0]  in_grs,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags
);

  logic        en;
  logic [4:0]  w_lz;
  logic [25:0] w_shifted;
  logic [9:0]  w_exp_ext;
  logic [9:0]  w_lz_ext;

  s1_payload_t s1_d;
  s1_payload_t s1_q;
  logic        s1_valid_q;

  logic              w_up;
  logic              w_inx;
  logic [FRAC_W:0]   w_frac_sum;
  logic              w_mant_ovf;
  logic signed [9:0] w_exp_r;
  logic [31:0]       result_d;
  logic [2:0]        flags_d;

  logic        out_valid_q;
  logic [31:0] out_result_q;
  logic [2:0]  out_flags_q;

  // Whole pipeline advances together; a held output freezes everything
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  lzc24 u_lzc (
    .data_i  (in_mant[23:0]),
    .count_o (w_lz)
  );

  // Left shift pulls guard then round into the mantissa; sticky never moves
  assign w_shifted = {in_mant[23:0], in_grs[2:1]} << w_lz;
  assign w_exp_ext = {2'b00, in_exp};
  assign w_lz_ext  = {5'b00000, w_lz};

  // Stage-1 normalize: classify the raw sum and renormalize it
  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_sign;
    if (in_exp == EXP_MAX) begin
      s1_d.special = 1'b1;
    end else if (in_mant[24]) begin
      s1_d.mant24 = in_mant[24:1];
      s1_d.grs    = {in_mant[0], in_grs[2], |in_grs[1:0]};
      s1_d.exp10  = w_exp_ext + 10'd1;
    end else if (in_mant == 25'd0 && in_grs == 3'd0) begin
      s1_d.zero = 1'b1;
      s1_d.sign = 1'b0;
    end else if ({3'b000, w_lz} < in_exp) begin
      s1_d.mant24 = w_shifted[25:2];
      s1_d.grs    = {w_shifted[1:0], in_grs[0]};
      s1_d.exp10  = w_exp_ext - w_lz_ext;
    end else begin
      s1_d.zero           = 1'b1;
      s1_d.flags[FLG_UNF] = 1'b1;
      s1_d.flags[FLG_INX] = (|in_grs) || (|in_mant);
    end
  end

  // Stage-1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      s1_q       <= s1_d;
    end
  end

  // Increment only the fraction; a carry out of it with the hidden bit set
  // is the all-ones mantissa rolling over to 1.0 at the next exponent.
  assign w_up       = s1_q.grs[2] && (s1_q.grs[1] || s1_q.grs[0] || s1_q.mant24[0]);
  assign w_inx      = |s1_q.grs;
  assign w_frac_sum = {1'b0, s1_q.mant24[FRAC_W-1:0]} + {{FRAC_W{1'b0}}, w_up};
  assign w_mant_ovf = s1_q.mant24[FRAC_W] && w_frac_sum[FRAC_W];
  assign w_exp_r    = w_mant_ovf ? s1_q.exp10 + 10'sd1 : s1_q.exp10;

  // Stage-2 round and pack
  always_comb begin
    result_d = '0;
    flags_d  = '0;
    if (s1_q.special) begin
      result_d = {s1_q.sign, EXP_MAX, {FRAC_W{1'b0}}};
    end else if (s1_q.zero) begin
      result_d = {s1_q.sign, 31'd0};
      flags_d  = s1_q.flags;
    end else if (w_exp_r >= 10'sd255) begin
      result_d         = {s1_q.sign, EXP_MAX, {FRAC_W{1'b0}}};
      flags_d[FLG_OVF] = 1'b1;
      flags_d[FLG_INX] = 1'b1;
    end else begin
      result_d         = {s1_q.sign, w_exp_r[EXP_W-1:0], w_frac_sum[FRAC_W-1:0]};
      flags_d[FLG_INX] = w_inx;
    end
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else if (en) begin
      out_valid_q  <= s1_valid_q;
      out_result_q <= result_d;
      out_flags_q  <= flags_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

endmodule : fp_norm_round
`default_nettype wire

// File: tb/tb_fp_norm_round.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_norm_round
//  Brief    : Scoreboard bench for fp_norm_round with directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [24:0] in_mant = '0;
  logic [2:0]  in_grs = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  fp_norm_round dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_grs     (in_grs),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    logic [2:0]  fmask;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: pop and compare on each handshake, watch stall behaviour
  logic [31:0] prev_res;
  logic [2:0]  prev_flg;
  bit          prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        if (prev_stall) begin
          check("stall_result_stable", out_result, prev_res);
          check("stall_flags_stable", {29'd0, out_flags}, {29'd0, prev_flg});
        end
        prev_stall = 1'b1;
        prev_res   = out_result;
        prev_flg   = out_flags;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got %h expected none", out_result);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", out_result, e.res);
          check("flags", {29'd0, out_flags & e.fmask}, {29'd0, e.flg & e.fmask});
          if (e.lat) check("latency", cyc - e.acc, 32'd2);
        end
      end
    end
  end

  // Present one operand set, push its expectation once it is accepted
  task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m,
                      input logic [2:0] g, input logic [31:0] r, input logic [2:0] f,
                      input logic [2:0] fm, input bit lat);
    int guard = 0;
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_grs   = g;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end else begin
      exp_q.push_back('{res: r, flg: f, fmask: fm, acc: cyc, lat: lat});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() > 0 && g < 100) begin
      @(posedge clk);
      g++;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_result", out_result, 32'd0);
    check("reset_out_flags", {29'd0, out_flags}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, back to back, no back-pressure
    send(0, 8'd127, 25'h0800000, 3'b000, 32'h3F800000, 3'b000, 3'b111, 1);
    send(0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 3'b000, 3'b111, 1);
    send(0, 8'd130, 25'h0100000, 3'b000, 32'h3F800000, 3'b000, 3'b111, 1);
    send(0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 3'b001, 3'b111, 1);
    send(0, 8'd127, 25'h0800000, 3'b100, 32'h3F800000, 3'b001, 3'b111, 1);
    send(0, 8'd254, 25'h0FFFFFF, 3'b110, 32'h7F800000, 3'b101, 3'b111, 1);
    send(0, 8'd5,   25'h0000001, 3'b000, 32'h00000000, 3'b010, 3'b110, 1);
    send(1, 8'hFF,  25'h0123456, 3'b111, 32'hFF800000, 3'b000, 3'b111, 1);
    send(1, 8'd100, 25'h0000000, 3'b000, 32'h00000000, 3'b000, 3'b111, 1);
    send(0, 8'd127, 25'h1000001, 3'b000, 32'h40000000, 3'b001, 3'b111, 1);
    send(1, 8'd3,   25'h0000010, 3'b001, 32'h80000000, 3'b011, 3'b111, 1);
    send(0, 8'd127, 25'h0400000, 3'b110, 32'h3F000002, 3'b001, 3'b111, 1);
    send(0, 8'd254, 25'h1000000, 3'b000, 32'h7F800000, 3'b101, 3'b111, 1);
    send(0, 8'd127, 25'h0FFFFFF, 3'b100, 32'h40000000, 3'b001, 3'b111, 1);
    drain();

    // Back-pressure: four inputs while the sink stalls
    fork
      begin
        send(0, 8'd127, 25'h0800000, 3'b000, 32'h3F800000, 3'b000, 3'b111, 0);
        send(0, 8'd128, 25'h0800000, 3'b000, 32'h40000000, 3'b000, 3'b111, 0);
        send(0, 8'd129, 25'h0800000, 3'b000, 32'h40800000, 3'b000, 3'b111, 0);
        send(0, 8'd130, 25'h0800000, 3'b000, 32'h41000000, 3'b000, 3'b111, 0);
      end
      begin
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a stall with both stages full
    out_ready = 1'b0;
    send(0, 8'd128, 25'h0800000, 3'b000, 32'h40000000, 3'b000, 3'b111, 0);
    send(0, 8'd129, 25'h0800000, 3'b000, 32'h40800000, 3'b000, 3'b111, 0);
    @(posedge clk);
    #1;
    check("prereset_out_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_out_result", out_result, 32'd0);
    check("midreset_out_flags", {29'd0, out_flags}, 32'd0);
    check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(0, 8'd127, 25'h0FFFFFF, 3'b100, 32'h40000000, 3'b001, 3'b111, 1);
    drain();
    repeat (3) @(posedge clk);
    #1;

    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fp_norm_round
`default_nettype wire
